// File: rtl/mac_pkg.sv
// Shared operand widths for the MAC datapath and its feeders.
// Pure constants; no logic, no latency.
// No flow control.
package MAC_PKG;
   localparam int IN1_WIDTH = 8;
   localparam int IN2_WIDTH = 8;
endpackage

// File: rtl/mac_operand_sequencer.sv
// Feeds one dot product of LEN operand pairs into the MAC: clear, load LEN pairs, wait out MAC latency, pulse DONE.
// Accepted pair reaches A/B/LOAD one cycle after its handshake; DONE lands MAC_LAT cycles after the last LOAD.
// IN_READY is high only in RUN; upstream may insert bubbles freely, and no more than LEN pairs are ever consumed.
module mac_operand_sequencer #(
   parameter int IN1_WIDTH = MAC_PKG::IN1_WIDTH,
   parameter int IN2_WIDTH = MAC_PKG::IN2_WIDTH,
   parameter int LEN_WIDTH = 8,
   parameter int MAC_LAT   = 1
) (
   input  logic                 SYS_CLK,
   input  logic                 SYS_RST_N,
   input  logic                 START,
   input  logic [LEN_WIDTH-1:0] LEN,
   input  logic                 IN_VALID,
   input  logic [IN1_WIDTH-1:0] IN_A,
   input  logic [IN2_WIDTH-1:0] IN_B,
   output logic                 IN_READY,
   output logic                 SCLR,
   output logic                 LOAD,
   output logic [IN1_WIDTH-1:0] A,
   output logic [IN2_WIDTH-1:0] B,
   output logic                 BUSY,
   output logic                 DONE
);

   // Drain counter counts down to zero; wide enough for MAC_LAT-1.
   localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   // After the last LOAD the DRAIN state lasts MAC_LAT cycles.
   localparam logic [DRN_W-1:0] DRN_RUN  = DRN_W'(MAC_LAT - 1);
   // With nothing loaded, the CLEAR cycle itself stands in for the last LOAD,
   // so DRAIN is one cycle shorter (and skipped entirely when MAC_LAT is 1).
   localparam logic [DRN_W-1:0] DRN_LEN0 = DRN_W'((MAC_LAT > 1) ? MAC_LAT - 2 : 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [LEN_WIDTH-1:0] rem, rem_nxt;
   logic [DRN_W-1:0]     drn, drn_nxt;
   logic                 sclr_nxt, load_nxt, busy_nxt, done_nxt;
   logic [IN1_WIDTH-1:0] a_nxt;
   logic [IN2_WIDTH-1:0] b_nxt;

   assign IN_READY = (state == ST_RUN);

   // State, counters and all MAC-facing outputs are registered here.
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         state <= ST_IDLE;
         rem   <= '0;
         drn   <= '0;
         SCLR  <= 1'b0;
         LOAD  <= 1'b0;
         A     <= '0;
         B     <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         drn   <= drn_nxt;
         SCLR  <= sclr_nxt;
         LOAD  <= load_nxt;
         A     <= a_nxt;
         B     <= b_nxt;
         BUSY  <= busy_nxt;
         DONE  <= done_nxt;
      end
   end

   // Next-state and next-output decode; SCLR/LOAD/DONE are pulses, A/B/BUSY hold.
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      drn_nxt   = drn;
      sclr_nxt  = 1'b0;
      load_nxt  = 1'b0;
      a_nxt     = A;
      b_nxt     = B;
      busy_nxt  = BUSY;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) begin
               rem_nxt   = LEN;
               sclr_nxt  = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (rem == '0) begin
               if (MAC_LAT == 1) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  drn_nxt   = DRN_LEN0;
                  state_nxt = ST_DRAIN;
               end
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (IN_VALID) begin
               a_nxt    = IN_A;
               b_nxt    = IN_B;
               load_nxt = 1'b1;
               rem_nxt  = rem - LEN_WIDTH'(1);
               if (rem == LEN_WIDTH'(1)) begin
                  drn_nxt   = DRN_RUN;
                  state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drn == '0) begin
               done_nxt  = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               drn_nxt = drn - DRN_W'(1);
            end
         end
         ST_DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench: two sequencers (MAC_LAT 1 and 3) share one stimulus stream, each feeding a small MAC model.
// MAC model output follows a LOAD by MAC_LAT edges.
// Upstream valid is driven directly; readiness is checked against hand-derived cycles.
module tb_mac_operand_sequencer;
   localparam int AW = MAC_PKG::IN1_WIDTH;
   localparam int BW = MAC_PKG::IN2_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n, start, in_vld;
   logic [7:0]    len;
   logic [AW-1:0] in_a;
   logic [BW-1:0] in_b;

   logic          rdy1, sclr1, load1, busy1, done1;
   logic [AW-1:0] a1;
   logic [BW-1:0] b1;
   logic          rdy3, sclr3, load3, busy3, done3;
   logic [AW-1:0] a3;
   logic [BW-1:0] b3;

   logic [31:0]   acc1, acc3, d31, d32, mac1, mac3;
   int            total = 0;
   int            bad = 0;
   int            nload;

   always #5 clk = ~clk;

   mac_operand_sequencer #(.LEN_WIDTH(8), .MAC_LAT(1)) u_lat1 (
      .SYS_CLK(clk), .SYS_RST_N(rst_n), .START(start), .LEN(len),
      .IN_VALID(in_vld), .IN_A(in_a), .IN_B(in_b), .IN_READY(rdy1),
      .SCLR(sclr1), .LOAD(load1), .A(a1), .B(b1), .BUSY(busy1), .DONE(done1)
   );

   mac_operand_sequencer #(.LEN_WIDTH(8), .MAC_LAT(3)) u_lat3 (
      .SYS_CLK(clk), .SYS_RST_N(rst_n), .START(start), .LEN(len),
      .IN_VALID(in_vld), .IN_A(in_a), .IN_B(in_b), .IN_READY(rdy3),
      .SCLR(sclr3), .LOAD(load3), .A(a3), .B(b3), .BUSY(busy3), .DONE(done3)
   );

   // MAC models: accumulator, plus two extra delay stages for the latency-3 instance.
   always @(posedge clk) begin
      if (sclr1) acc1 <= 32'd0;
      else if (load1) acc1 <= acc1 + 32'(a1) * 32'(b1);
      if (sclr3) acc3 <= 32'd0;
      else if (load3) acc3 <= acc3 + 32'(a3) * 32'(b3);
      d31 <= acc3;
      d32 <= d31;
   end
   assign mac1 = acc1;
   assign mac3 = d32;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = 8'd0; in_vld = 1'b0; in_a = '0; in_b = '0;
      tick(); tick();
      chk("rst_ctl1", 32'({sclr1, load1, busy1, done1, rdy1}), 0);
      chk("rst_a1", 32'(a1), 0);
      chk("rst_b1", 32'(b1), 0);
      chk("rst_ctl3", 32'({sclr3, load3, busy3, done3, rdy3}), 0);
      rst_n = 1'b1;
      tick();

      // 1: LEN=3 back-to-back, pair offered early during CLEAR is not consumed
      start = 1'b1; len = 8'd3; in_vld = 1'b1; in_a = 8'd3; in_b = 8'd1;
      tick();
      chk("t1_sclr", 32'(sclr1), 1);
      chk("t1_busy", 32'(busy1), 1);
      chk("t1_clr_rdy", 32'(rdy1), 0);
      chk("t1_clr_load", 32'(load1), 0);
      start = 1'b0;
      tick();
      chk("t1_run_rdy", 32'(rdy1), 1);
      chk("t1_run_sclr", 32'(sclr1), 0);
      chk("t1_run_load", 32'(load1), 0);
      tick();
      chk("t1_ld1", 32'({load1, a1, b1}), 32'({1'b1, 8'd3, 8'd1}));
      in_a = 8'd4; in_b = 8'd1;
      tick();
      chk("t1_ld2", 32'({load1, a1, b1}), 32'({1'b1, 8'd4, 8'd1}));
      in_a = 8'd5; in_b = 8'd2;
      tick();
      chk("t1_ld3", 32'({load1, a1, b1}), 32'({1'b1, 8'd5, 8'd2}));
      chk("t1_drain_rdy", 32'(rdy1), 0);
      in_vld = 1'b0;
      tick();
      chk("t1_done", 32'({done1, busy1, load1}), 32'(3'b110));
      chk("t1_mac", mac1, 17);
      tick();
      chk("t1_after", 32'({done1, busy1}), 0);
      idle(4);

      // 2: LEN=3 with two bubbles between first and second pair
      start = 1'b1; len = 8'd3;
      tick();
      start = 1'b0;
      tick();
      in_vld = 1'b1; in_a = 8'd3; in_b = 8'd1;
      tick();
      chk("t2_ld1", 32'({load1, a1, b1}), 32'({1'b1, 8'd3, 8'd1}));
      in_vld = 1'b0;
      tick();
      chk("t2_bub1", 32'({load1, a1, b1}), 32'({1'b0, 8'd3, 8'd1}));
      tick();
      chk("t2_bub2", 32'({load1, a1, b1}), 32'({1'b0, 8'd3, 8'd1}));
      in_vld = 1'b1; in_a = 8'd4; in_b = 8'd1;
      tick();
      chk("t2_ld2", 32'({load1, a1, b1}), 32'({1'b1, 8'd4, 8'd1}));
      in_a = 8'd5; in_b = 8'd2;
      tick();
      chk("t2_ld3", 32'({load1, a1, b1}), 32'({1'b1, 8'd5, 8'd2}));
      in_vld = 1'b0;
      tick();
      chk("t2_done", 32'(done1), 1);
      chk("t2_mac", mac1, 17);
      idle(5);

      // 3: LEN=0, valid offered but never consumed
      start = 1'b1; len = 8'd0;
      tick();
      chk("t3_sclr", 32'({sclr1, rdy1}), 32'(2'b10));
      start = 1'b0; in_vld = 1'b1;
      tick();
      chk("t3_done1", 32'({done1, load1, rdy1}), 32'(3'b100));
      chk("t3_mac1", mac1, 0);
      chk("t3_lat3_early", 32'(done3), 0);
      tick();
      chk("t3_idle1", 32'({done1, busy1, rdy1}), 0);
      chk("t3_lat3_wait", 32'({done3, busy3, rdy3}), 32'(3'b010));
      tick();
      chk("t3_done3", 32'(done3), 1);
      chk("t3_mac3", mac3, 0);
      in_vld = 1'b0;
      idle(4);

      // 4: START re-asserted with LEN=5 during a LEN=2 run, dropped before IDLE
      start = 1'b1; len = 8'd2;
      tick();
      start = 1'b0;
      tick();
      in_vld = 1'b1; in_a = 8'd1; in_b = 8'd2; start = 1'b1; len = 8'd5;
      tick();
      chk("t4_ld1", 32'({load1, a1}), 32'({1'b1, 8'd1}));
      in_a = 8'd3; in_b = 8'd4;
      tick();
      chk("t4_ld2", 32'({load1, a1, rdy1}), 32'({1'b1, 8'd3, 1'b0}));
      in_vld = 1'b0; start = 1'b0;
      tick();
      chk("t4_done", 32'({done1, load1}), 32'(2'b10));
      chk("t4_mac", mac1, 14);
      tick();
      chk("t4_no_redone", 32'({done1, busy1, sclr1}), 0);
      tick();
      chk("t4_no_restart", 32'({sclr1, busy1}), 0);
      idle(3);

      // 4b: START held high through a LEN=1 op restarts after one idle cycle
      start = 1'b1; len = 8'd1;
      tick();
      tick();
      in_vld = 1'b1; in_a = 8'd2; in_b = 8'd2;
      tick();
      chk("t4b_ld", 32'(load1), 1);
      in_vld = 1'b0;
      tick();
      chk("t4b_done", 32'(done1), 1);
      tick();
      chk("t4b_gap", 32'({busy1, sclr1}), 0);
      tick();
      chk("t4b_restart", 32'({sclr1, busy1}), 32'(2'b11));
      start = 1'b0;
      tick();
      in_vld = 1'b1; in_a = 8'd1; in_b = 8'd1;
      tick();
      in_vld = 1'b0;
      tick();
      chk("t4b_done2", 32'(done1), 1);
      chk("t4b_mac2", mac1, 1);
      idle(4);

      // 5: reset after 1 of 4 pairs, then fresh LEN=2 run
      start = 1'b1; len = 8'd4;
      tick();
      start = 1'b0;
      tick();
      in_vld = 1'b1; in_a = 8'd9; in_b = 8'd9;
      tick();
      chk("t5_ld1", 32'(load1), 1);
      in_vld = 1'b0; rst_n = 1'b0;
      tick();
      chk("t5_rst_ctl", 32'({sclr1, load1, busy1, done1, rdy1}), 0);
      chk("t5_rst_ab", 32'({a1, b1}), 0);
      rst_n = 1'b1;
      tick();
      chk("t5_no_done", 32'({done1, busy1, rdy1}), 0);
      start = 1'b1; len = 8'd2;
      tick();
      start = 1'b0;
      tick();
      in_vld = 1'b1; in_a = 8'd2; in_b = 8'd3;
      tick();
      in_a = 8'd6; in_b = 8'd1;
      tick();
      in_vld = 1'b0;
      tick();
      chk("t5_done", 32'(done1), 1);
      chk("t5_mac", mac1, 12);
      idle(5);

      // Max LEN=255: no counter wrap, exactly 255 loads
      start = 1'b1; len = 8'd255;
      tick();
      start = 1'b0;
      tick();
      nload = 0;
      for (int i = 0; i < 255; i++) begin
         in_vld = 1'b1; in_a = 8'd1; in_b = 8'd1;
         tick();
         if (load1) nload++;
      end
      chk("max_drain_rdy", 32'(rdy1), 0);
      in_vld = 1'b0;
      tick();
      chk("max_done", 32'(done1), 1);
      chk("max_mac", mac1, 255);
      chk("max_nload", 32'(nload), 255);
      idle(6);

      // 6: MAC_LAT=3, LEN=2, (7,2),(1,1)
      start = 1'b1; len = 8'd2;
      tick();
      chk("t6_sclr3", 32'(sclr3), 1);
      start = 1'b0;
      tick();
      chk("t6_rdy3", 32'(rdy3), 1);
      in_vld = 1'b1; in_a = 8'd7; in_b = 8'd2;
      tick();
      chk("t6_ld1", 32'({load3, a3, b3}), 32'({1'b1, 8'd7, 8'd2}));
      in_a = 8'd1; in_b = 8'd1;
      tick();
      chk("t6_ld2", 32'({load3, a3, b3}), 32'({1'b1, 8'd1, 8'd1}));
      in_vld = 1'b0;
      tick();
      chk("t6_wait1", 32'({done3, load3}), 0);
      tick();
      chk("t6_wait2", 32'(done3), 0);
      chk("t6_mac_partial", mac3, 14);
      tick();
      chk("t6_done", 32'({done3, busy3}), 32'(2'b11));
      chk("t6_mac", mac3, 15);
      tick();
      chk("t6_after", 32'({done3, busy3}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
